// File: rtl/prach_conv_mixer_pkg.sv
// Shared types and constants for the PRACH conversion mixer slice.
package prach_pkg;

  localparam int NcoFrac = 14;
  localparam int ChnW    = 8;

  // One complex 16-bit value; used here for the registered NCO phasor (i = cos, q = sin).
  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
  } iq16_t;

endpackage

// File: rtl/prach_conv_mixer_if.sv
// TDM sample/NCO input bundle and mixed output bundle of prach_conv_mixer.
// master drives samples and NCO values; slave is the mixer.
interface prach_conv_mixer_if
  import prach_pkg::*;
#(
  parameter int DW    = 16,
  parameter int CHN_W = ChnW
);

  logic                    sync_in;
  logic signed [DW-1:0]    din_i;
  logic signed [DW-1:0]    din_q;
  logic signed [15:0]      nco_cos;
  logic signed [15:0]      nco_sin;
  logic        [CHN_W-1:0] nco_chn;

  logic signed [DW-1:0]    dout_i;
  logic signed [DW-1:0]    dout_q;
  logic        [CHN_W-1:0] dout_chn;
  logic                    dout_sat;
  logic                    sync_out;
  logic                    align_err;

  modport master (
    output sync_in, din_i, din_q, nco_cos, nco_sin, nco_chn,
    input  dout_i, dout_q, dout_chn, dout_sat, sync_out, align_err
  );

  modport slave (
    input  sync_in, din_i, din_q, nco_cos, nco_sin, nco_chn,
    output dout_i, dout_q, dout_chn, dout_sat, sync_out, align_err
  );

endinterface

// File: rtl/prach_conv_mixer_rnd_sat.sv
// One rail of the mixer output stage: optional round-half-up, arithmetic
// shift by NCO_FRAC, saturation to DW bits, registered with a sat flag.
// Build option: PRACH_CONV_MIXER_ROUND_EN selects rounding; otherwise floor.
module prach_conv_mixer_rnd_sat #(
  parameter int DW       = 16,
  parameter int NCO_FRAC = 14,
  parameter int IW       = 33
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [IW-1:0] din,
  output logic signed [DW-1:0] dout,
  output logic                 sat
);

  // One guard bit so the rounding bias can never overflow the sum.
  localparam int AW = IW + 1;

`ifdef PRACH_CONV_MIXER_ROUND_EN
  localparam logic signed [AW-1:0] RndBias = AW'(2 ** (NCO_FRAC - 1));
`else
  localparam logic signed [AW-1:0] RndBias = '0;
`endif

  localparam logic signed [AW-1:0] MaxV = (AW'(1) <<< (DW - 1)) - AW'(1);
  localparam logic signed [AW-1:0] MinV = -(AW'(1) <<< (DW - 1));

  logic signed [AW-1:0] biased;
  logic signed [AW-1:0] shifted;

  // Bias and scale back to sample units.
  always_comb begin
    biased  = AW'(din) + RndBias;
    shifted = biased >>> NCO_FRAC;
  end

  // Clamp to the DW range and flag when clamping happened.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
      sat  <= 1'b0;
    end else if (shifted > MaxV) begin
      dout <= MaxV[DW-1:0];
      sat  <= 1'b1;
    end else if (shifted < MinV) begin
      dout <= MinV[DW-1:0];
      sat  <= 1'b1;
    end else begin
      dout <= shifted[DW-1:0];
      sat  <= 1'b0;
    end
  end

endmodule

// File: rtl/prach_delay.sv
// Fixed-depth shift-register delay line with synchronous active-high clear.
module prach_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] pipe [DEPTH];

  // Shift one stage per cycle; reset clears every stage.
  // NOTE: every stage is reset (not just the last) so a reset flushes
  // in-flight tags instead of letting them emerge after reset releases.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/prach_conv_mixer.sv
// Complex down-conversion mixer: y = din * conj(nco) on a 2**CHN_W slot TDM
// stream, 4-cycle fixed latency, with a sticky sample/NCO channel alignment check.
// Build option: PRACH_CONV_MIXER_ROUND_EN (round half up instead of floor).
module prach_conv_mixer
  import prach_pkg::*;
#(
  parameter int DW       = 16,
  parameter int NCO_FRAC = NcoFrac,
  parameter int CHN_W    = ChnW
) (
  input  logic              clk,
  input  logic              rst,
  prach_conv_mixer_if.slave bus
);

  localparam int PW = DW + 16;  // product width
  localparam int SW = PW + 1;   // sum width
  localparam logic [CHN_W-1:0] ChnOne = CHN_W'(1);

  logic [CHN_W-1:0] chn_q;
  logic [CHN_W-1:0] chn_cur;
  logic             locked_q;
  logic             align_err_q;
  logic             chn_mismatch;

  // Channel tag of the sample presented this cycle and the alignment test.
  // The sync cycle itself counts as locked so a bad NCO tag on sync is caught.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    chn_cur = chn_q + ChnOne;
    if (bus.sync_in) chn_cur = '0;
    chn_mismatch = (locked_q || bus.sync_in) && (bus.nco_chn != chn_cur);
  end

  // Channel counter, lock flag and sticky alignment error.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      chn_q       <= '0;
      locked_q    <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      chn_q <= chn_cur;
      if (bus.sync_in) locked_q    <= 1'b1;
      if (chn_mismatch) align_err_q <= 1'b1;
    end
  end

  assign bus.align_err = align_err_q;

  // S1: register sample and phasor.
  logic signed [DW-1:0] s1_di;
  logic signed [DW-1:0] s1_dq;
  iq16_t                s1_nco;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_di  <= '0;
      s1_dq  <= '0;
      s1_nco <= '0;
    end else begin
      s1_di    <= bus.din_i;
      s1_dq    <= bus.din_q;
      s1_nco.i <= bus.nco_cos;
      s1_nco.q <= bus.nco_sin;
    end
  end

  // S2: the four full-precision products.
  logic signed [PW-1:0] p_ic, p_qs, p_qc, p_is;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_ic <= '0;
      p_qs <= '0;
      p_qc <= '0;
      p_is <= '0;
    end else begin
      p_ic <= PW'(s1_di) * PW'($signed(s1_nco.i));
      p_qs <= PW'(s1_dq) * PW'($signed(s1_nco.q));
      p_qc <= PW'(s1_dq) * PW'($signed(s1_nco.i));
      p_is <= PW'(s1_di) * PW'($signed(s1_nco.q));
    end
  end

  // S3: conjugate-phasor combine; one extra bit keeps the sums exact.
  logic signed [SW-1:0] s3_yi, s3_yq;

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_yi <= '0;
      s3_yq <= '0;
    end else begin
      s3_yi <= SW'(p_ic) + SW'(p_qs);
      s3_yq <= SW'(p_qc) - SW'(p_is);
    end
  end

  // S4: round/shift/saturate per rail.
  logic sat_i, sat_q;

  prach_conv_mixer_rnd_sat #(.DW(DW), .NCO_FRAC(NCO_FRAC), .IW(SW)) u_rnd_sat_i (
    .clk  (clk),
    .rst  (rst),
    .din  (s3_yi),
    .dout (bus.dout_i),
    .sat  (sat_i)
  );

  prach_conv_mixer_rnd_sat #(.DW(DW), .NCO_FRAC(NCO_FRAC), .IW(SW)) u_rnd_sat_q (
    .clk  (clk),
    .rst  (rst),
    .din  (s3_yq),
    .dout (bus.dout_q),
    .sat  (sat_q)
  );

  assign bus.dout_sat = sat_i | sat_q;

  // Channel tag and sync travel alongside the data for the same 4 cycles.
  logic [CHN_W:0] tag_in, tag_out;

  assign tag_in = {bus.sync_in, chn_cur};

  prach_delay #(.W(CHN_W + 1), .DEPTH(4)) u_tag_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (tag_in),
    .dout (tag_out)
  );

  assign bus.sync_out = tag_out[CHN_W];
  assign bus.dout_chn = tag_out[CHN_W-1:0];

endmodule
